// File: rtl/control_sequencer_if.sv
// ---------------------------------------------------------------------------
// control_sequencer_if
//   Bundle between the hardwired control unit and the 32-bit bus datapath.
//
//   Inputs to the sequencer:  Stop (pause request), IR (instruction register),
//                             CON (branch-condition flip-flop).
//   Outputs of the sequencer: ldin (register load enables), bout (bus drivers),
//                             gsel (register-file select strobes), Read, write,
//                             IncPC, ALUop, Run.
//
//   master: the control sequencer.  slave: the datapath.
// ---------------------------------------------------------------------------
interface control_sequencer_if #(
    parameter int OPW = 5
);
    logic           Stop;
    logic [31:0]    IR;
    logic           CON;

    logic [9:0]     ldin;   // {HIin,LOin,PCin,MDRin,Zin,Yin,MARin,IRin,CONin,OUTPORTin}
    logic [9:0]     bout;   // {HIout,LOout,ZHIout,ZLOout,PCout,MDRout,INPORTout,OUTPORTout,Cout,Yout}
    logic [5:0]     gsel;   // {Gra,Grb,Grc,Rin,Rout,BAout}
    logic           Read;
    logic           write;
    logic           IncPC;
    logic [OPW-1:0] ALUop;
    logic           Run;

    modport master (
        input  Stop, IR, CON,
        output ldin, bout, gsel, Read, write, IncPC, ALUop, Run
    );

    modport slave (
        output Stop, IR, CON,
        input  ldin, bout, gsel, Read, write, IncPC, ALUop, Run
    );
endinterface

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//   Moore FSM that sequences the bus datapath through fetch (T0..T2) and the
//   opcode-dependent execute steps (T3..T7).  Every strobe is decoded from the
//   state register plus the IR opcode (and CON for the conditional branch).
//
//   Ports:
//     Clock  - system clock, rising edge
//     Reset  - asynchronous, active-high; forces RST (all outputs 0)
//     bus    - control_sequencer_if.master: Stop/IR/CON in, strobes out
// ---------------------------------------------------------------------------
module control_sequencer #(
    parameter int             OPW    = 5,
    parameter logic [OPW-1:0] ADD_OP = OPW'(5'b00011)
) (
    input  logic                Clock,
    input  logic                Reset,
    control_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        RST, T0, T1, T2, T3, T4, T5, T6, T7, PAUSE, HALT
    } state_t;

    // Opcodes (IR[31:27])
    localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
    localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01010);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01011);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01101);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01110);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b01111);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10000);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10001);
    localparam logic [OPW-1:0] OP_BR   = OPW'(5'b10010);
    localparam logic [OPW-1:0] OP_JR   = OPW'(5'b10011);
    localparam logic [OPW-1:0] OP_IN   = OPW'(5'b10110);
    localparam logic [OPW-1:0] OP_OUT  = OPW'(5'b10111);
    localparam logic [OPW-1:0] OP_MFHI = OPW'(5'b11000);
    localparam logic [OPW-1:0] OP_MFLO = OPW'(5'b11001);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    // Bit positions inside ldin
    localparam int L_HI = 9, L_LO = 8, L_PC = 7, L_MDR = 6, L_Z = 5;
    localparam int L_Y = 4, L_MAR = 3, L_IR = 2, L_CON = 1, L_OUT = 0;
    // Bit positions inside bout
    localparam int B_HI = 9, B_LO = 8, B_ZHI = 7, B_ZLO = 6, B_PC = 5;
    localparam int B_MDR = 4, B_IN = 3, B_OUT = 2, B_C = 1, B_Y = 0;
    // Bit positions inside gsel
    localparam int G_A = 5, G_B = 4, G_C = 3, G_RIN = 2, G_ROUT = 1, G_BA = 0;

    state_t         state;
    state_t         last;       // final execute step of the current opcode
    state_t         t0_entry;   // T0, or PAUSE when a stop is pending
    logic [OPW-1:0] op;

    logic is_ld, is_ldi, is_st, is_mem, is_r, is_i, is_md, is_neg;
    logic unused_ir;

    assign op        = bus.IR[31 -: OPW];
    assign unused_ir = ^bus.IR[31-OPW:0];

    assign is_ld  = (op == OP_LD);
    assign is_ldi = (op == OP_LDI);
    assign is_st  = (op == OP_ST);
    assign is_mem = is_ld || is_ldi || is_st;
    assign is_r   = (op >= OP_ADD)  && (op <= OP_ROL);
    assign is_i   = (op >= OP_ADDI) && (op <= OP_ORI);
    assign is_md  = (op == OP_MUL)  || (op == OP_DIV);
    assign is_neg = (op == OP_NEG)  || (op == OP_NOT);

    // Stop is only honoured on the way into T0, i.e. at instruction boundaries.
    assign t0_entry = bus.Stop ? PAUSE : T0;

    always_comb begin
        if (is_ld || is_st)                      last = T7;
        else if (is_ldi || is_r || is_i)         last = T5;
        else if (is_md || op == OP_BR)           last = T6;
        else if (is_neg)                         last = T4;
        else if (op == OP_JR  || op == OP_IN  || op == OP_OUT ||
                 op == OP_MFHI || op == OP_MFLO) last = T3;
        else                                     last = T2;  // nop, halt, undefined
    end

    // The T2 exit reads IR directly: the fetched opcode must already be on IR
    // at the T2->T3 edge for nop/halt/undefined to skip execution.
    // NOTE: sequential state uses non-blocking assignments so every flop in the
    // design samples pre-edge values, regardless of block evaluation order.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= RST;
        end else begin
            case (state)
                RST:   state <= t0_entry;
                T0:    state <= T1;
                T1:    state <= T2;
                T2:    if (op == OP_HALT)  state <= HALT;
                       else if (last == T2) state <= t0_entry;
                       else                state <= T3;
                T3:    state <= (last == T3) ? t0_entry : T4;
                T4:    state <= (last == T4) ? t0_entry : T5;
                T5:    state <= (last == T5) ? t0_entry : T6;
                T6:    state <= (last == T6) ? t0_entry : T7;
                T7:    state <= t0_entry;
                PAUSE: if (!bus.Stop) state <= T0;
                HALT:  state <= HALT;
                default: state <= RST;
            endcase
        end
    end

    logic [9:0]     ldin, bout;
    logic [5:0]     gsel;
    logic           rd, wr, inc_pc;
    logic [OPW-1:0] alu_op;

    // NOTE: every output gets a default before the case, so a state/opcode
    // combination that assigns nothing yields 0 instead of inferring a latch.
    always_comb begin
        ldin   = '0;
        bout   = '0;
        gsel   = '0;
        rd     = 1'b0;
        wr     = 1'b0;
        inc_pc = 1'b0;
        alu_op = '0;
        case (state)
            T0: begin bout[B_PC] = 1'b1; ldin[L_MAR] = 1'b1; end
            T1: begin rd = 1'b1; ldin[L_MDR] = 1'b1; ldin[L_PC] = 1'b1; inc_pc = 1'b1; end
            T2: begin bout[B_MDR] = 1'b1; ldin[L_IR] = 1'b1; end
            T3: begin
                if (is_mem) begin
                    gsel[G_B] = 1'b1; gsel[G_BA] = 1'b1; ldin[L_Y] = 1'b1;
                end else if (is_r || is_i) begin
                    gsel[G_B] = 1'b1; gsel[G_ROUT] = 1'b1; ldin[L_Y] = 1'b1;
                end else if (is_md) begin
                    gsel[G_A] = 1'b1; gsel[G_ROUT] = 1'b1; ldin[L_Y] = 1'b1;
                end else if (is_neg) begin
                    gsel[G_B] = 1'b1; gsel[G_ROUT] = 1'b1; ldin[L_Z] = 1'b1; alu_op = op;
                end else if (op == OP_BR) begin
                    gsel[G_A] = 1'b1; gsel[G_ROUT] = 1'b1; ldin[L_CON] = 1'b1;
                end else if (op == OP_JR) begin
                    gsel[G_A] = 1'b1; gsel[G_ROUT] = 1'b1; ldin[L_PC] = 1'b1;
                end else if (op == OP_IN) begin
                    bout[B_IN] = 1'b1; gsel[G_A] = 1'b1; gsel[G_RIN] = 1'b1;
                end else if (op == OP_OUT) begin
                    gsel[G_A] = 1'b1; gsel[G_ROUT] = 1'b1; ldin[L_OUT] = 1'b1;
                end else if (op == OP_MFHI) begin
                    bout[B_HI] = 1'b1; gsel[G_A] = 1'b1; gsel[G_RIN] = 1'b1;
                end else if (op == OP_MFLO) begin
                    bout[B_LO] = 1'b1; gsel[G_A] = 1'b1; gsel[G_RIN] = 1'b1;
                end
            end
            T4: begin
                if (is_mem || is_i) begin
                    bout[B_C] = 1'b1; ldin[L_Z] = 1'b1;
                    alu_op = is_mem ? ADD_OP : op;
                end else if (is_r) begin
                    gsel[G_C] = 1'b1; gsel[G_ROUT] = 1'b1; ldin[L_Z] = 1'b1; alu_op = op;
                end else if (is_md) begin
                    gsel[G_B] = 1'b1; gsel[G_ROUT] = 1'b1; ldin[L_Z] = 1'b1; alu_op = op;
                end else if (is_neg) begin
                    bout[B_ZLO] = 1'b1; gsel[G_A] = 1'b1; gsel[G_RIN] = 1'b1;
                end else if (op == OP_BR) begin
                    bout[B_PC] = 1'b1; ldin[L_Y] = 1'b1;
                end
            end
            T5: begin
                if (is_ld || is_st) begin
                    bout[B_ZLO] = 1'b1; ldin[L_MAR] = 1'b1;
                end else if (is_ldi || is_r || is_i) begin
                    bout[B_ZLO] = 1'b1; gsel[G_A] = 1'b1; gsel[G_RIN] = 1'b1;
                end else if (is_md) begin
                    bout[B_ZLO] = 1'b1; ldin[L_LO] = 1'b1;
                end else if (op == OP_BR) begin
                    bout[B_C] = 1'b1; ldin[L_Z] = 1'b1; alu_op = ADD_OP;
                end
            end
            T6: begin
                if (is_ld) begin
                    rd = 1'b1; ldin[L_MDR] = 1'b1;
                end else if (is_st) begin
                    gsel[G_A] = 1'b1; gsel[G_ROUT] = 1'b1; ldin[L_MDR] = 1'b1;
                end else if (is_md) begin
                    bout[B_ZHI] = 1'b1; ldin[L_HI] = 1'b1;
                end else if (op == OP_BR) begin
                    // Branch target always computed; only committed when taken.
                    bout[B_ZLO] = 1'b1; ldin[L_PC] = bus.CON;
                end
            end
            T7: begin
                if (is_ld) begin
                    bout[B_MDR] = 1'b1; gsel[G_A] = 1'b1; gsel[G_RIN] = 1'b1;
                end else if (is_st) begin
                    wr = 1'b1;
                end
            end
            default: ;  // RST, PAUSE, HALT: all strobes idle
        endcase
    end

    assign bus.ldin  = ldin;
    assign bus.bout  = bout;
    assign bus.gsel  = gsel;
    assign bus.Read  = rd;
    assign bus.write = wr;
    assign bus.IncPC = inc_pc;
    assign bus.ALUop = alu_op;
    assign bus.Run   = (state != RST) && (state != PAUSE) && (state != HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
//   Directed bench for control_sequencer: walks instructions step by step and
//   compares the full strobe vector {ldin,bout,gsel,Read,write,IncPC,ALUop,Run}
//   against hand-written expectations, sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

    logic Clock = 1'b0;
    logic Reset;

    control_sequencer_if bus_if ();

    control_sequencer dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus_if)
    );

    always #5 Clock = ~Clock;

    // ldin bits
    localparam logic [9:0] L_HI = 10'h200, L_LO = 10'h100, L_PC = 10'h080, L_MDR = 10'h040;
    localparam logic [9:0] L_Z = 10'h020, L_Y = 10'h010, L_MAR = 10'h008, L_IR = 10'h004;
    localparam logic [9:0] L_CON = 10'h002;
    // bout bits
    localparam logic [9:0] B_ZHI = 10'h080, B_ZLO = 10'h040, B_PC = 10'h020, B_MDR = 10'h010;
    localparam logic [9:0] B_C = 10'h002;
    // gsel bits
    localparam logic [5:0] G_A = 6'h20, G_B = 6'h10, G_C = 6'h08, G_RIN = 6'h04;
    localparam logic [5:0] G_ROUT = 6'h02, G_BA = 6'h01;

    localparam logic [31:0] IR_ADD  = 32'h1A920000;
    localparam logic [31:0] IR_ST   = 32'h12000090;
    localparam logic [31:0] IR_BR   = 32'h90000000;
    localparam logic [31:0] IR_MUL  = 32'h70000000;
    localparam logic [31:0] IR_NOP  = 32'hD0000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] vec(input logic [9:0] ld, input logic [9:0] bo,
                                        input logic [5:0] gs, input logic rd, input logic wr,
                                        input logic inc, input logic [4:0] alu, input logic run);
        return {ld, bo, gs, rd, wr, inc, alu, run};
    endfunction

    // Shorthand for an active step with no Read/write/IncPC
    function automatic logic [34:0] ex(input logic [9:0] ld, input logic [9:0] bo,
                                       input logic [5:0] gs, input logic [4:0] alu);
        return vec(ld, bo, gs, 1'b0, 1'b0, 1'b0, alu, 1'b1);
    endfunction

    task automatic chk(input string tag, input logic [34:0] exp);
        check(tag, 64'({bus_if.ldin, bus_if.bout, bus_if.gsel, bus_if.Read, bus_if.write,
                        bus_if.IncPC, bus_if.ALUop, bus_if.Run}), 64'(exp));
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Checks T0, T1, T2 and advances into the first execute step.
    task automatic fetch(input string tag);
        chk({tag, "_t0"}, ex(L_MAR, B_PC, 6'h00, 5'd0));
        step();
        chk({tag, "_t1"}, vec(L_MDR | L_PC, 10'h000, 6'h00, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1));
        step();
        chk({tag, "_t2"}, ex(L_IR, B_MDR, 6'h00, 5'd0));
        step();
    endtask

    initial begin
        Reset         = 1'b1;
        bus_if.Stop   = 1'b0;
        bus_if.CON    = 1'b0;
        bus_if.IR     = IR_ADD;
        #2;
        chk("rst_idle", '0);
        step();
        chk("rst_held", '0);
        Reset = 1'b0;
        step();

        // Reset mid-T4 of add
        fetch("add_a");
        chk("add_a_t3", ex(L_Y, 10'h000, G_B | G_ROUT, 5'd0));
        step();
        chk("add_a_t4", ex(L_Z, 10'h000, G_C | G_ROUT, 5'b00011));
        Reset = 1'b1;
        #1;
        chk("rst_async", '0);
        Reset = 1'b0;
        step();
        check("rst_t0_pcout", 64'(bus_if.bout[5]), 64'(1));
        check("rst_t0_marin", 64'(bus_if.ldin[3]), 64'(1));

        // st 0x90,R4: eight steps then T0
        bus_if.IR = IR_ST;
        fetch("st");
        chk("st_t3", ex(L_Y, 10'h000, G_B | G_BA, 5'd0));
        step();
        chk("st_t4", ex(L_Z, B_C, 6'h00, 5'b00011));
        step();
        chk("st_t5", ex(L_MAR, B_ZLO, 6'h00, 5'd0));
        step();
        chk("st_t6", ex(L_MDR, 10'h000, G_A | G_ROUT, 5'd0));
        step();
        chk("st_t7", vec(10'h000, 10'h000, 6'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1));
        step();

        // add R5,R2,R4: six steps then T0
        bus_if.IR = IR_ADD;
        fetch("add");
        chk("add_t3", ex(L_Y, 10'h000, G_B | G_ROUT, 5'd0));
        step();
        chk("add_t4", ex(L_Z, 10'h000, G_C | G_ROUT, 5'b00011));
        step();
        chk("add_t5", ex(10'h000, B_ZLO, G_A | G_RIN, 5'd0));
        step();

        // br, not taken then taken
        for (int c = 0; c < 2; c++) begin
            bus_if.IR  = IR_BR;
            bus_if.CON = c[0];
            fetch(c == 0 ? "br_nt" : "br_tk");
            chk("br_t3", ex(L_CON, 10'h000, G_A | G_ROUT, 5'd0));
            step();
            chk("br_t4", ex(L_Y, B_PC, 6'h00, 5'd0));
            step();
            chk("br_t5", ex(L_Z, B_C, 6'h00, 5'b00011));
            step();
            chk(c == 0 ? "br_nt_t6" : "br_tk_t6", ex(c == 0 ? 10'h000 : L_PC, B_ZLO, 6'h00, 5'd0));
            step();
        end
        bus_if.CON = 1'b0;

        // mul
        bus_if.IR = IR_MUL;
        fetch("mul");
        chk("mul_t3", ex(L_Y, 10'h000, G_A | G_ROUT, 5'd0));
        step();
        chk("mul_t4", ex(L_Z, 10'h000, G_B | G_ROUT, 5'b01110));
        step();
        chk("mul_t5", ex(L_LO, B_ZLO, 6'h00, 5'd0));
        step();
        chk("mul_t6", ex(L_HI, B_ZHI, 6'h00, 5'd0));
        step();

        // nop: T2 straight back to T0
        bus_if.IR = IR_NOP;
        fetch("nop");

        // Stop raised during T5 of add: finish, then PAUSE until Stop drops
        bus_if.IR = IR_ADD;
        fetch("add_p");
        step();
        step();
        chk("add_p_t5", ex(10'h000, B_ZLO, G_A | G_RIN, 5'd0));
        bus_if.Stop = 1'b1;
        step();
        chk("pause_enter", '0);
        step();
        chk("pause_hold", '0);
        bus_if.Stop = 1'b0;
        step();
        chk("pause_exit_t0", ex(L_MAR, B_PC, 6'h00, 5'd0));

        // halt: idle until reset
        bus_if.IR = IR_HALT;
        fetch("halt");
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("halt_idle%0d", i), '0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Hardwired control unit that sequences the 32-bit bus-based datapath through fetch and execute steps.
- Drives every register-enable, bus-driver and select strobe, plus memory Read/write, IncPC and the ALU op code.
- Sits above the datapath. It replaces hand-driven strobe sequences with a Moore FSM decoded from the IR opcode.
- Consumes IR and the CON flip-flop output.

Parameters:
OPW, 5, opcode width (IR[31:27]).
ADD_OP, 5'b00011, ALU op code issued for address/offset additions.

Ports:
Clock  input  1  system clock, all state changes on rising edge
Reset  input  1  asynchronous, active-high; forces state RST
Stop  input  1  pause request, sampled at instruction boundary
IR  input  32  instruction register contents
CON  input  1  branch-condition flip-flop output
ldin  output  10  {HIin,LOin,PCin,MDRin,Zin,Yin,MARin,IRin,CONin,OUTPORTin}, bit 9 = HIin
bout  output  10  {HIout,LOout,ZHIout,ZLOout,PCout,MDRout,INPORTout,OUTPORTout,Cout,Yout}, bit 9 = HIout
gsel  output  6  {Gra,Grb,Grc,Rin,Rout,BAout}, bit 5 = Gra
Read  output  1  memory read / MDR source select
write  output  1  memory write strobe
IncPC  output  1  PC increment with PCin
ALUop  output  5  ALU function code; 0 when unused
Run  output  1  1 while fetching/executing

Behaviour:
- One clock; Reset is asynchronous and active-high.
- Outputs are purely combinational from the state register (Moore). They are valid for the whole cycle, and the datapath latches on the next rising edge.
- Reset: state forced to RST immediately. All outputs are 0 while in RST. The first rising edge after Reset falls moves RST->T0. Reset mid-instruction aborts it with no partial strobes.
- States: RST, T0..T7, PAUSE, HALT. Non-listed strobes are 0 in every step.
- Fetch:
  - T0: PCout, MARin.
  - T1: Read, MDRin, PCin, IncPC.
  - T2: MDRout, IRin.
- Decode uses IR[31:27] sampled during T3..T7. IR is stable from the end of T2. Last step listed per class returns to T0.
- ld 00000: T3 Grb,BAout,Yin; T4 Cout,Zin,ALUop=ADD_OP; T5 ZLOout,MARin; T6 Read,MDRin; T7 MDRout,Gra,Rin.
- ldi 00001: T3 as ld; T4 as ld; T5 ZLOout,Gra,Rin.
- st 00010: T3,T4,T5 as ld; T6 Gra,Rout,MDRin; T7 write only.
- R-type 00011..01010 (add,sub,and,or,shr,shl,ror,rol): T3 Grb,Rout,Yin; T4 Grc,Rout,Zin,ALUop=opcode; T5 ZLOout,Gra,Rin.
- I-type 01011..01101 (addi,andi,ori): T3 Grb,Rout,Yin; T4 Cout,Zin,ALUop=opcode; T5 ZLOout,Gra,Rin.
- mul/div 01110/01111: T3 Gra,Rout,Yin; T4 Grb,Rout,Zin,ALUop=opcode; T5 ZLOout,LOin; T6 ZHIout,HIin.
- neg/not 10000/10001: T3 Grb,Rout,Zin,ALUop=opcode; T4 ZLOout,Gra,Rin.
- br 10010: T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,Zin,ALUop=ADD_OP; T6 ZLOout, plus PCin only if CON=1 during T6.
- jr 10011: T3 Gra,Rout,PCin.
- in 10110: T3 INPORTout,Gra,Rin. out 10111: T3 Gra,Rout,OUTPORTin.
- mfhi 11000: T3 HIout,Gra,Rin. mflo 11001: T3 LOout,Gra,Rin.
- nop 11010 and all undefined opcodes: T2->T0 directly.
- halt 11011: T2->HALT. HALT holds until Reset.
- Stop handling: at any transition into T0 with Stop=1, the FSM goes to PAUSE instead. PAUSE->T0 on the first edge with Stop=0. Stop is ignored mid-instruction.
- Run: 0 in RST, PAUSE and HALT; 1 otherwise.

Test Plan:
1. Reset mid-T4 of add (IR=32'h1A920000):
   - Outputs all 0 and Run=0 within the same timestep.
   - Release Reset; one edge later, T0 shows bout[PCout]=1 and ldin[MARin]=1.
2. st 0x90,R4 (IR=32'h12000090):
   - T3 Grb,BAout,Yin; T4 Cout,Zin,ALUop=00011; T5 ZLOout,MARin; T6 Gra,Rout,MDRin; T7 write=1 alone.
   - 8 cycles T0..T7, then T0.
3. add R5,R2,R4 (IR=32'h1A920000):
   - T4 Grc,Rout,Zin with ALUop=00011; T5 ZLOout,Gra,Rin.
   - Next edge returns to T0 (6-cycle instruction).
4. br opcode 10010:
   - CON=0: T6 has ZLOout=1, PCin=0.
   - Repeat with CON=1: T6 has PCin=1.
5. mul opcode 01110:
   - T5 asserts ZLOout+LOin; T6 asserts ZHIout+HIin; HIin/LOin never together.
6. halt and pause:
   - IR op 11011: after T2, Run=0 and all strobes 0 for 10+ cycles.
   - Separately, Stop=1 during T5 of add: completes T5, enters PAUSE.
   - Stop=0: next edge goes to T0.
